// File: rtl/l1_msi_controller.sv
// L1 MSI cache controller: 4-line direct-mapped cache, one CPU access at a time.
// Ports: Cpu* request/response, DirReq*/DirRsp* directory channel, Probe* snoops.
module l1_msi_controller #(
    parameter int PROC_ID = 0,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 4
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              CpuValid,
    input  logic              CpuWrite,
    input  logic [ADDR_W-1:0] CpuAddress,
    input  logic [DATA_W-1:0] CpuData,
    output logic              CpuReady,
    output logic [DATA_W-1:0] CpuDataOut,
    output logic              CpuHit,
    output logic              DirReqValid,
    output logic [1:0]        DirReqType,
    output logic [ADDR_W-1:0] DirReqAddress,
    output logic [DATA_W-1:0] DirReqData,
    output logic [1:0]        DirReqProc,
    input  logic              DirReqReady,
    input  logic              DirRspValid,
    input  logic [DATA_W-1:0] DirRspData,
    input  logic              ProbeValid,
    input  logic [1:0]        ProbeType,
    input  logic [ADDR_W-1:0] ProbeAddress,
    output logic              ProbeAck,
    output logic [DATA_W-1:0] ProbeData
);

    typedef enum logic [2:0] {
        IDLE, WB_REQ, WB_WAIT, MISS_REQ, MISS_WAIT, DONE
    } state_t;

    localparam logic [2:0] ST_EMPTY = 3'b000;
    localparam logic [2:0] ST_I     = 3'b001;
    localparam logic [2:0] ST_S     = 3'b010;
    localparam logic [2:0] ST_M     = 3'b011;

    state_t state, stateNext;

    logic [2:0]        lineState [4];
    logic [ADDR_W-1:0] lineTag   [4];
    logic [DATA_W-1:0] lineData  [4];

    logic              reqWrite;
    logic [ADDR_W-1:0] reqAddr;
    logic [DATA_W-1:0] reqData;
    logic [1:0]        reqType;
    logic [ADDR_W-1:0] wbAddr;
    logic [DATA_W-1:0] wbData;
    logic [DATA_W-1:0] cpuDataQ;
    logic              cpuHitQ;
    logic              probeAckQ;
    logic [DATA_W-1:0] probeDataQ;

    // Probe evaluation; the ack register doubles as the one-cycle re-fire guard
    logic              probeFire;
    logic [1:0]        probeIdx;
    logic              probeMatch;
    logic [2:0]        probeNext;
    logic [DATA_W-1:0] probeOut;

    assign probeFire  = ProbeValid && !probeAckQ && (state != DONE);
    assign probeIdx   = ProbeAddress[1:0];
    assign probeMatch = (lineTag[probeIdx] == ProbeAddress) &&
                        (lineState[probeIdx] == ST_S || lineState[probeIdx] == ST_M);
    assign probeOut   = (probeMatch && ProbeType[1]) ? lineData[probeIdx] : '0;

    always_comb begin
        probeNext = lineState[probeIdx];
        if (probeMatch) begin
            case (ProbeType)
                2'b01:   probeNext = ST_I;
                2'b10:   probeNext = ST_S;
                2'b11:   probeNext = ST_I;
                default: probeNext = lineState[probeIdx];
            endcase
        end
    end

    // CPU lookup sees the line state after a same-cycle probe
    logic [1:0] cpuIdx;
    logic [2:0] lookState;
    logic       tagEq, isHit, isUpgrade, needWb, capture;

    assign cpuIdx    = CpuAddress[1:0];
    assign lookState = (probeFire && probeIdx == cpuIdx) ? probeNext : lineState[cpuIdx];
    assign tagEq     = lineTag[cpuIdx] == CpuAddress;
    assign isHit     = tagEq && (lookState == ST_M || (lookState == ST_S && !CpuWrite));
    assign isUpgrade = tagEq && CpuWrite && lookState == ST_S;
    assign needWb    = !tagEq && lookState == ST_M;
    assign capture   = (state == IDLE) && CpuValid;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) state <= IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (CpuValid) begin
                    if (isHit)       stateNext = DONE;
                    else if (needWb) stateNext = WB_REQ;
                    else             stateNext = MISS_REQ;
                end
            end
            WB_REQ:    if (DirReqReady) stateNext = WB_WAIT;
            WB_WAIT:   if (DirRspValid) stateNext = MISS_REQ;
            MISS_REQ:  if (DirReqReady) stateNext = MISS_WAIT;
            MISS_WAIT: if (DirRspValid) stateNext = DONE;
            DONE:      stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    always_comb begin
        CpuReady      = state == DONE;
        CpuDataOut    = cpuDataQ;
        CpuHit        = (state == DONE) && cpuHitQ;
        DirReqValid   = (state == WB_REQ) || (state == MISS_REQ);
        DirReqType    = 2'b00;
        DirReqAddress = '0;
        DirReqData    = '0;
        DirReqProc    = 2'(PROC_ID);
        ProbeAck      = probeAckQ;
        ProbeData     = probeDataQ;
        if (state == WB_REQ) begin
            DirReqType    = 2'b11;
            DirReqAddress = wbAddr;
            DirReqData    = wbData;
        end else if (state == MISS_REQ) begin
            DirReqType    = reqType;
            DirReqAddress = reqAddr;
        end
    end

    // Cache arrays and request capture; later writes in this block take
    // priority, so a fill overrides a same-cycle probe on the same line
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < 4; i++) begin
                lineState[i] <= ST_EMPTY;
                lineTag[i]   <= '0;
                lineData[i]  <= '0;
            end
            reqWrite   <= 1'b0;
            reqAddr    <= '0;
            reqData    <= '0;
            reqType    <= 2'b00;
            wbAddr     <= '0;
            wbData     <= '0;
            cpuDataQ   <= '0;
            cpuHitQ    <= 1'b0;
            probeAckQ  <= 1'b0;
            probeDataQ <= '0;
        end else begin
            probeAckQ  <= probeFire;
            probeDataQ <= probeFire ? probeOut : '0;
            if (probeFire) lineState[probeIdx] <= probeNext;

            if (capture) begin
                reqWrite <= CpuWrite;
                reqAddr  <= CpuAddress;
                reqData  <= CpuData;
                reqType  <= isUpgrade ? 2'b10 : {1'b0, CpuWrite};
                wbAddr   <= lineTag[cpuIdx];
                wbData   <= lineData[cpuIdx];
                if (isHit) begin
                    if (CpuWrite) lineData[cpuIdx] <= CpuData;
                    cpuDataQ <= CpuWrite ? CpuData : lineData[cpuIdx];
                    cpuHitQ  <= 1'b1;
                end
            end

            if (state == WB_WAIT && DirRspValid)
                lineState[reqAddr[1:0]] <= ST_I;

            if (state == MISS_WAIT && DirRspValid) begin
                lineTag[reqAddr[1:0]]   <= reqAddr;
                lineData[reqAddr[1:0]]  <= reqWrite ? reqData : DirRspData;
                lineState[reqAddr[1:0]] <= reqWrite ? ST_M : ST_S;
                cpuDataQ                <= reqWrite ? reqData : DirRspData;
                cpuHitQ                 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_l1_msi_controller.sv
// Directed bench for l1_msi_controller: a hand-scripted directory and prober
// drive the misses, upgrades, write-backs and probes with fixed expectations.
module tb_l1_msi_controller;

    logic       Clock = 1'b0;
    logic       ResetN = 1'b1;
    logic       CpuValid = 1'b0;
    logic       CpuWrite = 1'b0;
    logic [3:0] CpuAddress = '0;
    logic [3:0] CpuData = '0;
    logic       CpuReady;
    logic [3:0] CpuDataOut;
    logic       CpuHit;
    logic       DirReqValid;
    logic [1:0] DirReqType;
    logic [3:0] DirReqAddress;
    logic [3:0] DirReqData;
    logic [1:0] DirReqProc;
    logic       DirReqReady = 1'b0;
    logic       DirRspValid = 1'b0;
    logic [3:0] DirRspData = '0;
    logic       ProbeValid = 1'b0;
    logic [1:0] ProbeType = '0;
    logic [3:0] ProbeAddress = '0;
    logic       ProbeAck;
    logic [3:0] ProbeData;

    int tests = 0;
    int fails = 0;

    always #5 Clock = ~Clock;

    l1_msi_controller #(.PROC_ID(1), .ADDR_W(4), .DATA_W(4)) dut (
        .Clock(Clock), .ResetN(ResetN),
        .CpuValid(CpuValid), .CpuWrite(CpuWrite),
        .CpuAddress(CpuAddress), .CpuData(CpuData),
        .CpuReady(CpuReady), .CpuDataOut(CpuDataOut), .CpuHit(CpuHit),
        .DirReqValid(DirReqValid), .DirReqType(DirReqType),
        .DirReqAddress(DirReqAddress), .DirReqData(DirReqData),
        .DirReqProc(DirReqProc), .DirReqReady(DirReqReady),
        .DirRspValid(DirRspValid), .DirRspData(DirRspData),
        .ProbeValid(ProbeValid), .ProbeType(ProbeType),
        .ProbeAddress(ProbeAddress), .ProbeAck(ProbeAck), .ProbeData(ProbeData)
    );

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic startCpu(input logic w, input logic [3:0] a, input logic [3:0] d);
        CpuValid   = 1'b1;
        CpuWrite   = w;
        CpuAddress = a;
        CpuData    = d;
        tick();
    endtask

    // Expects a request to be showing now; accepts it after 'delay' stalled cycles
    task automatic dirReq(input string tag, input logic [1:0] t, input logic [3:0] a,
                          input logic [3:0] d, input int delay);
        chk({tag, ".valid"}, 8'(DirReqValid), 8'd1);
        chk({tag, ".type"}, 8'(DirReqType), 8'(t));
        chk({tag, ".addr"}, 8'(DirReqAddress), 8'(a));
        chk({tag, ".data"}, 8'(DirReqData), 8'(d));
        for (int i = 0; i < delay; i++) begin
            tick();
            chk({tag, ".heldValid"}, 8'(DirReqValid), 8'd1);
            chk({tag, ".heldFields"}, {DirReqType, DirReqAddress, 2'b00}, {t, a, 2'b00});
        end
        DirReqReady = 1'b1;
        tick();
        DirReqReady = 1'b0;
        chk({tag, ".drop"}, 8'(DirReqValid), 8'd0);
    endtask

    task automatic dirRsp(input logic [3:0] d);
        DirRspValid = 1'b1;
        DirRspData  = d;
        tick();
        DirRspValid = 1'b0;
        DirRspData  = '0;
    endtask

    task automatic cpuDone(input string tag, input logic [3:0] d, input logic hit);
        chk({tag, ".ready"}, 8'(CpuReady), 8'd1);
        chk({tag, ".dataOut"}, 8'(CpuDataOut), 8'(d));
        chk({tag, ".hit"}, 8'(CpuHit), 8'(hit));
        CpuValid = 1'b0;
        tick();
        chk({tag, ".readyPulse"}, 8'(CpuReady), 8'd0);
    endtask

    task automatic probe(input string tag, input logic [1:0] t, input logic [3:0] a,
                         input logic [3:0] d);
        ProbeValid   = 1'b1;
        ProbeType    = t;
        ProbeAddress = a;
        tick();
        chk({tag, ".ack"}, 8'(ProbeAck), 8'd1);
        chk({tag, ".data"}, 8'(ProbeData), 8'(d));
        ProbeValid = 1'b0;
        tick();
        chk({tag, ".ackPulse"}, 8'(ProbeAck), 8'd0);
    endtask

    initial begin
        #1 ResetN = 1'b0;
        tick();
        tick();
        chk("rst.cpuReady", 8'(CpuReady), 8'd0);
        chk("rst.dirValid", 8'(DirReqValid), 8'd0);
        chk("rst.dirType", 8'(DirReqType), 8'd0);
        chk("rst.dirProc", 8'(DirReqProc), 8'd1);
        chk("rst.probeAck", 8'(ProbeAck), 8'd0);
        chk("rst.dataOut", 8'(CpuDataOut), 8'd0);
        ResetN = 1'b1;
        tick();

        // cold load miss, directory stalls two cycles
        startCpu(1'b0, 4'b0010, 4'b0000);
        dirReq("rdMiss", 2'b00, 4'b0010, 4'b0000, 2);
        dirRsp(4'b0001);
        cpuDone("rdMiss", 4'b0001, 1'b0);

        // repeat load hits with latency 1
        startCpu(1'b0, 4'b0010, 4'b0000);
        chk("rdHit.noReq", 8'(DirReqValid), 8'd0);
        cpuDone("rdHit", 4'b0001, 1'b1);

        // store to S line upgrades to M
        startCpu(1'b1, 4'b0010, 4'b1001);
        dirReq("upg", 2'b10, 4'b0010, 4'b0000, 0);
        dirRsp(4'b0001);
        cpuDone("upg", 4'b1001, 1'b0);

        // fetch on M, then on the resulting S line
        probe("fetchM", 2'b10, 4'b0010, 4'b1001);
        probe("fetchS", 2'b10, 4'b0010, 4'b1001);

        // invalidate with tag mismatch leaves the line alone
        probe("invMiss", 2'b01, 4'b0110, 4'b0000);
        startCpu(1'b0, 4'b0010, 4'b0000);
        cpuDone("afterInvMiss", 4'b1001, 1'b1);

        // fetch+invalidate during a pending upgrade of the same line
        startCpu(1'b1, 4'b0010, 4'b0100);
        dirReq("upg2", 2'b10, 4'b0010, 4'b0000, 0);
        probe("fetchInvUpg", 2'b11, 4'b0010, 4'b1001);
        probe("afterInvI", 2'b10, 4'b0010, 4'b0000);
        dirRsp(4'b0011);
        cpuDone("upg2", 4'b0100, 1'b0);
        probe("fetchNewM", 2'b10, 4'b0010, 4'b0100);

        // line1 to M, store hit in M, then conflicting load forces write-back
        startCpu(1'b1, 4'b0001, 4'b0010);
        dirReq("wrMiss", 2'b01, 4'b0001, 4'b0000, 0);
        dirRsp(4'b0111);
        cpuDone("wrMiss", 4'b0010, 1'b0);
        startCpu(1'b1, 4'b0001, 4'b0011);
        chk("wrHitM.noReq", 8'(DirReqValid), 8'd0);
        cpuDone("wrHitM", 4'b0011, 1'b1);
        startCpu(1'b0, 4'b0101, 4'b0000);
        dirReq("wb", 2'b11, 4'b0001, 4'b0011, 1);
        dirRsp(4'b0000);
        dirReq("wbFill", 2'b00, 4'b0101, 4'b0000, 0);
        dirRsp(4'b0110);
        cpuDone("wbFill", 4'b0110, 1'b0);
        probe("staleTag", 2'b11, 4'b0001, 4'b0000);
        probe("fetchInv", 2'b11, 4'b0101, 4'b0110);
        startCpu(1'b0, 4'b0101, 4'b0000);
        dirReq("reMiss", 2'b00, 4'b0101, 4'b0000, 0);
        dirRsp(4'b1000);
        cpuDone("reMiss", 4'b1000, 1'b0);

        // reset while waiting for a fill
        startCpu(1'b0, 4'b0011, 4'b0000);
        dirReq("rstMiss", 2'b00, 4'b0011, 4'b0000, 0);
        CpuValid = 1'b0;
        ResetN = 1'b0;
        #1;
        chk("midRst.dirValid", 8'(DirReqValid), 8'd0);
        chk("midRst.cpuReady", 8'(CpuReady), 8'd0);
        tick();
        tick();
        ResetN = 1'b1;
        tick();
        chk("postRst.idle", 8'(DirReqValid), 8'd0);
        startCpu(1'b0, 4'b0010, 4'b0000);
        dirReq("postRst", 2'b00, 4'b0010, 4'b0000, 0);
        dirRsp(4'b0101);
        cpuDone("postRst", 4'b0101, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/l1_msi_controller.md
Name: l1_msi_controller

Overview:
- Per-processor L1 cache controller directly upstream of the MSI directory (L2 list).
- Services one CPU load/store at a time from a 4-line direct-mapped cache holding MSI state.
- Issues read-miss / write-miss / upgrade / write-back requests to the directory and services directory-initiated invalidate/fetch probes.
- One instance per processor (P0, P1).

Parameters:
- PROC_ID, 0, processor number driven on DirReqProc (0 = P0_0, 1 = P0_1).
- ADDR_W, 4, address code width (0000 empty, 0001=100 … 1000=138).
- DATA_W, 4, data code width (0000 empty, 0001=08 … 1001=90).

Ports:
- Clock  in  1  system clock; all state updates on posedge.
- ResetN  in  1  asynchronous, active-low reset.
- CpuValid  in  1  CPU request present; held until CpuReady.
- CpuWrite  in  1  1 = store, 0 = load.
- CpuAddress  in  ADDR_W  request address code.
- CpuData  in  DATA_W  store data.
- CpuReady  out  1  one-cycle completion pulse.
- CpuDataOut  out  DATA_W  load result; valid with CpuReady, held until the next CpuReady.
- CpuHit  out  1  1 = the completed access hit; valid with CpuReady.
- DirReqValid  out  1  directory request valid.
- DirReqType  out  2  00 read miss, 01 write miss, 10 upgrade (S->M invalidate), 11 write-back.
- DirReqAddress  out  ADDR_W  request address.
- DirReqData  out  DATA_W  write-back data (0000 otherwise).
- DirReqProc  out  2  PROC_ID.
- DirReqReady  in  1  directory accepts the request this cycle.
- DirRspValid  in  1  directory response (fill data or write-back ack).
- DirRspData  in  DATA_W  fill data.
- ProbeValid  in  1  directory probe; held until ProbeAck.
- ProbeType  in  2  01 invalidate, 10 fetch (M->S), 11 fetch+invalidate.
- ProbeAddress  in  ADDR_W  probed address.
- ProbeAck  out  1  one-cycle probe completion pulse.
- ProbeData  out  DATA_W  line data on fetch; 0000 otherwise.

Behaviour:
- Line state codes: 000 empty, 001 I, 010 S, 011 M. Index = address[1:0]. Each line stores the full address code as its tag.
- Hit: line state is S or M and tag == address.
- Reset (ResetN low, any time, including mid-transaction):
  - all lines state 000, tag 0000, data 0000;
  - FSM to IDLE;
  - every output 0, except DirReqProc = PROC_ID.
- FSM states: IDLE, WB_REQ, WB_WAIT, MISS_REQ, MISS_WAIT, DONE.
- IDLE with CpuValid (captures CpuWrite, CpuAddress, CpuData):
  - Load hit (S/M) or store hit in M: store writes data, state stays M; go DONE. CpuReady is high on the cycle after capture, so hit latency is 1.
  - Store hit in S: MISS_REQ with type 10.
  - Miss with victim in M and different tag: WB_REQ first (type 11, victim tag and data).
  - Miss otherwise: MISS_REQ directly, type 00 for a load, 01 for a store. A victim in S or I is dropped silently.
- WB_REQ / MISS_REQ:
  - DirReqValid held high with stable fields until a cycle with DirReqReady high.
  - Next state is WB_WAIT or MISS_WAIT respectively. DirReqValid drops the following cycle.
- WB_WAIT, on DirRspValid: victim line becomes I, then MISS_REQ.
- MISS_WAIT, on DirRspValid: line tag = address, data = DirRspData. Then:
  - a store overwrites data with CpuData and sets state M;
  - a load sets state S;
  - go DONE. CpuHit = 0 in this path.
- DONE: CpuReady = 1 for one cycle; CpuDataOut = line data; return to IDLE.
- Probes:
  - Serviced in any FSM state except DONE when ProbeValid = 1 and ProbeAck was 0 the previous cycle.
  - ProbeAck pulses the next cycle, so probe latency is 1.
  - If a probe and a CPU capture occur in the same IDLE cycle, the probe is applied first and the CPU lookup sees the post-probe state.
  - Probe tag mismatch, or line in I or empty: no state change; ProbeAck still pulses; ProbeData = 0000.
  - 01 invalidate: line becomes I.
  - 10 fetch: M becomes S, ProbeData = line data.
  - 11 fetch+invalidate: ProbeData = line data, line becomes I.
- Probe hitting the line of a pending upgrade (MISS_WAIT, type 10): state is changed as above. The later fill still installs DirRspData and then CpuData, so the line ends in M.
- A probe arriving after a fill is installed sees the new line.
- A second CpuValid is not sampled until the cycle after CpuReady.
- DirRspValid is ignored outside WB_WAIT and MISS_WAIT.

Test Plan:
- Reset mid-MISS_WAIT (ResetN low for 2 cycles) -> all lines 000, DirReqValid 0, FSM IDLE; a load of 0010 then issues type 00.
- Load 0010 (108) on cold cache, DirReqReady after 2 cycles, DirRspData 0001 -> DirReqType 00, line2 = S/0010/0001, CpuDataOut 0001, CpuHit 0; repeat load -> CpuReady next cycle, CpuHit 1.
- Store 1001 to 0010 while in S -> type 10 issued; on DirRspData 0001 the line ends M/1001.
- Line1 in M (tag 0001, data 0010); load 0101 (120) -> write-back type 11 with addr 0001, data 0010, then type 00 for 0101.
- Probe 10 to a line in M -> ProbeAck one cycle later, ProbeData = line data, state 010; probe 01 to a tag mismatch -> ProbeAck, state unchanged.
- Probe 11 during a pending upgrade of the same line -> ProbeAck, line I; after the fill (0011) and store (0100), line = M/0100.
